// File: rtl/eth_mii_rx_sampler.sv
// ---------------------------------------------------------------------------
// eth_mii_rx_sampler
//
// Oversamples the asynchronous 10 Mbps MII receive interface in the
// rx_clk125 domain. It recovers nibble timing from the falling edge of
// mii_rx_clk, strips the preamble and SFD, and assembles bytes with the low
// nibble first. The result is a byte stream with sof/eof/error flags for the
// MAC receive path.
//
// Ports
//   rx_clk125    in   125 MHz clock; all logic runs on its rising edge
//   rst          in   synchronous reset, active high
//   mii_rx_clk   in   PHY receive clock (~2.5 MHz, asynchronous)
//   mii_rxd      in   PHY receive nibble (asynchronous)
//   mii_rx_dv    in   PHY data valid (asynchronous)
//   mii_rx_er    in   PHY receive error (asynchronous)
//   rx_data      out  assembled byte; meaningful only while rx_valid=1
//   rx_valid     out  one-cycle strobe per byte
//   rx_sof       out  with rx_valid on the first byte after the SFD
//   rx_eof       out  one-cycle strobe at frame end; never with rx_valid
//   rx_frame_err out  qualifies rx_eof: 1 = bad frame
//
// Handshake: there is no back-pressure. rx_valid and rx_eof are
// single-cycle strobes that the consumer must accept in the cycle they are
// high. rx_data is valid only in a cycle where rx_valid=1. rx_frame_err is
// valid only in a cycle where rx_eof=1.
// ---------------------------------------------------------------------------
module eth_mii_rx_sampler #(
    parameter int TIMEOUT_CYCLES = 120,
    parameter int CNT_W          = 8
) (
    input  logic       rx_clk125,
    input  logic       rst,
    input  logic       mii_rx_clk,
    input  logic [3:0] mii_rxd,
    input  logic       mii_rx_dv,
    input  logic       mii_rx_er,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       rx_frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    // Synchronisers. The clock gets a third stage so that an edge can be
    // detected between the second and third stages.
    logic       clk_s1, clk_s2, clk_s3;
    logic [3:0] rxd_s1, rxd_s2;
    logic       dv_s1, dv_s2;
    logic       er_s1, er_s2;

    state_t     state, state_n;
    logic [CNT_W-1:0] cnt;
    logic       phase, phase_n;
    logic [3:0] low, low_n;
    logic       err, err_n;
    logic       first, first_n;
    logic [7:0] data_n;
    logic       valid_n, sof_n, eof_n, ferr_n;
    logic       tick;
    logic       timeout;

    // The data is sampled on the falling edge of mii_rx_clk, which is the
    // middle of the data eye.
    assign tick    = ~clk_s2 & clk_s3;
    assign timeout = (cnt >= CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge rx_clk125) begin
        if (rst) begin
            clk_s1 <= 1'b0; clk_s2 <= 1'b0; clk_s3 <= 1'b0;
            rxd_s1 <= 4'h0; rxd_s2 <= 4'h0;
            dv_s1  <= 1'b0; dv_s2  <= 1'b0;
            er_s1  <= 1'b0; er_s2  <= 1'b0;
        end else begin
            clk_s1 <= mii_rx_clk; clk_s2 <= clk_s1; clk_s3 <= clk_s2;
            rxd_s1 <= mii_rxd;    rxd_s2 <= rxd_s1;
            dv_s1  <= mii_rx_dv;  dv_s2  <= dv_s1;
            er_s1  <= mii_rx_er;  er_s2  <= er_s1;
        end
    end

    // This counter measures the time since the last tick. It saturates so
    // that a long idle period cannot wrap it back below the threshold.
    always_ff @(posedge rx_clk125) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge rx_clk125) begin
        if (rst) begin
            state        <= ST_IDLE;
            phase        <= 1'b0;
            low          <= 4'h0;
            err          <= 1'b0;
            first        <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_sof       <= 1'b0;
            rx_eof       <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            low          <= low_n;
            err          <= err_n;
            first        <= first_n;
            rx_data      <= data_n;
            rx_valid     <= valid_n;
            rx_sof       <= sof_n;
            rx_eof       <= eof_n;
            rx_frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        low_n   = low;
        err_n   = err;
        first_n = first;
        data_n  = rx_data;
        valid_n = 1'b0;
        sof_n   = 1'b0;
        eof_n   = 1'b0;
        ferr_n  = 1'b0;

        if (tick) begin
            // A tick always takes priority over the timeout. The counter
            // clears in the same cycle, so there is no abort.
            unique case (state)
                ST_IDLE: begin
                    if (dv_s2) begin
                        state_n = (rxd_s2 == 4'h5) ? ST_PREAMBLE : ST_DROP;
                    end
                end
                ST_PREAMBLE: begin
                    if (!dv_s2) begin
                        state_n = ST_IDLE;
                    end else if (rxd_s2 == 4'hD) begin
                        state_n = ST_DATA;
                        phase_n = 1'b0;
                        err_n   = 1'b0;
                        first_n = 1'b1;
                    end else if (rxd_s2 != 4'h5) begin
                        state_n = ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (dv_s2) begin
                        if (er_s2) err_n = 1'b1;
                        if (!phase) begin
                            low_n   = rxd_s2;
                            phase_n = 1'b1;
                        end else begin
                            data_n  = {rxd_s2, low};
                            valid_n = 1'b1;
                            sof_n   = first;
                            first_n = 1'b0;
                            phase_n = 1'b0;
                        end
                    end else begin
                        // If dv drops while a low nibble is still waiting
                        // for its high half, the frame has a trailing half
                        // byte and is marked bad.
                        eof_n   = 1'b1;
                        ferr_n  = err | phase;
                        phase_n = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!dv_s2) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (timeout && state != ST_IDLE) begin
            state_n = ST_IDLE;
            phase_n = 1'b0;
            if (state == ST_DATA) begin
                eof_n  = 1'b1;
                ferr_n = 1'b1;
            end
        end
    end

endmodule
